// File: rtl/fifo_arb_pkg.sv
// Shared types and width helper for the FIFO write-port arbiter.
// Optional build macro FIFO_WR_ARB_HIPRI_EN (used by fifo_rr_pick) gives requester 0 absolute priority.
package fifo_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_e;

    // Never returns zero, so an index or counter always has at least one bit.
    function automatic int safe_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Rotating-priority picker: first requester above last_id, wrapping around.
// With FIFO_WR_ARB_HIPRI_EN defined, requester 0 wins whenever it requests.
module fifo_rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]                 req,
    input  logic [safe_clog2(NUM_REQ)-1:0]     last_id,
    output logic [safe_clog2(NUM_REQ)-1:0]     pick_id,
    output logic                               pick_valid
);

    localparam int ID_W = safe_clog2(NUM_REQ);

    // Two passes: indices above last_id first, then the wrapped-around lower ones.
    always_comb begin
        pick_valid = 1'b0;
        pick_id    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pick_valid && req[i] && (ID_W'(i) > last_id)) begin
                pick_valid = 1'b1;
                pick_id    = ID_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pick_valid && req[i] && (ID_W'(i) <= last_id)) begin
                pick_valid = 1'b1;
                pick_id    = ID_W'(i);
            end
        end
`ifdef FIFO_WR_ARB_HIPRI_EN
        if (req[0]) begin
            pick_valid = 1'b1;
            pick_id    = '0;
        end
`endif
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters, bounded bursts.
// Build macro FIFO_WR_ARB_HIPRI_EN selects the requester-0 priority picker.
module fifo_wr_arb
    import fifo_arb_pkg::*;
#(
    parameter int FIFO_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 8
) (
    input  logic                          clk,
    input  logic                          rstN,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          wr_en,
    output logic [FIFO_WIDTH-1:0]         data_in,
    input  logic                          full,
    output logic                          busy
);

    localparam int ID_W  = safe_clog2(NUM_REQ);
    localparam int CNT_W = safe_clog2(MAX_BURST + 1);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
    logic [ID_W-1:0]    last_id_q, last_id_d;
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic [ID_W-1:0]    pick_id;
    logic               pick_valid;
    logic               owner_req;

    fifo_rr_pick #(
        .NUM_REQ(NUM_REQ)
    ) u_pick (
        .req       (req),
        .last_id   (last_id_q),
        .pick_id   (pick_id),
        .pick_valid(pick_valid)
    );

    assign owner_req = |(req & gnt_q);
    assign gnt       = gnt_q;
    assign busy      = (state_q == ARB_BURST);

    // Writes only happen in BURST, so reset (which forces IDLE) kills any in-flight write.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        last_id_d   = last_id_q;
        burst_cnt_d = burst_cnt_q;
        wr_en       = 1'b0;
        ack         = '0;
        data_in     = '0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d     = ARB_BURST;
                    gnt_d       = NUM_REQ'(1) << pick_id;
                    gnt_id_d    = pick_id;
                    burst_cnt_d = '0;
                end
            end
            ARB_BURST: begin
                wr_en = owner_req & ~full;
                ack   = gnt_q & {NUM_REQ{wr_en}};
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (wr_en && gnt_q[i]) begin
                        data_in = req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
                    end
                end
                if (wr_en) begin
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                end
                if (!owner_req || (wr_en && (burst_cnt_q == CNT_W'(MAX_BURST - 1)))) begin
                    state_d   = ARB_IDLE;
                    gnt_d     = '0;
                    last_id_d = gnt_id_q;
                end
            end
        endcase
    end

    // last_id resets to the top index so requester 0 is first in line.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q     <= ARB_IDLE;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            last_id_q   <= ID_W'(NUM_REQ - 1);
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            last_id_q   <= last_id_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

endmodule
